// File: rtl/ppi_pkg.sv
// ppi_pkg: shared FSM states, 8255A register selects and mode-0 control words
// for the PPI bus master.
package ppi_pkg;

  typedef enum logic [2:0] {
    ST_PRST,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOV
  } ppi_state_e;

  localparam logic [1:0] PPI_PORTA = 2'b00;
  localparam logic [1:0] PPI_PORTB = 2'b01;
  localparam logic [1:0] PPI_PORTC = 2'b10;
  localparam logic [1:0] PPI_CTRL  = 2'b11;

  // Mode-0 control words: all ports output, and port A input with the rest output.
  localparam logic [7:0] PPI_CW_ALL_OUT = 8'h80;
  localparam logic [7:0] PPI_CW_A_IN    = 8'h90;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ppi_cyc_timer.sv
// ppi_cyc_timer: loadable down-counter shared by every timed state;
// o_done marks the final clock of the loaded interval.
module ppi_cyc_timer #(
  parameter int W       = 3,
  parameter int RST_VAL = 4
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nReset)
    if (!nReset)             r_cnt <= W'(RST_VAL);
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: turns single-beat host requests into timed 8255A bus cycles
// and sequences the PPI reset pin. Optional macro PPI_BUS_RECOVERY_EN adds a RECOV gap.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RESET_CYC  = 4
`ifdef PPI_BUS_RECOVERY_EN
  , parameter int RECOV_CYC = 3
`endif
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       soft_rst,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       nCs,
  output logic       nRe,
  output logic       nWr,
  output logic       ppi_reset,
  output logic [1:0] A,
  inout  wire  [7:0] D
);

`ifdef PPI_BUS_RECOVERY_EN
  localparam int  MAXC = max2(max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, RESET_CYC)), RECOV_CYC);
  localparam bit  BAD_RECOV = (RECOV_CYC < 1) || (RECOV_CYC > 15);
`else
  localparam int  MAXC = max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, RESET_CYC));
  localparam bit  BAD_RECOV = 1'b0;
`endif
  localparam int  W = $clog2(MAXC + 1);
  localparam bit  BAD = (SETUP_CYC < 1) || (SETUP_CYC > 15) || (STROBE_CYC < 1) || (STROBE_CYC > 15) ||
                        (HOLD_CYC < 1) || (HOLD_CYC > 15) || (RESET_CYC < 1) || (RESET_CYC > 255) || BAD_RECOV;

  generate
    if (BAD) begin : g_bad_param
      $error("ppi_bus_master: timing parameter out of range");
    end
  endgenerate

  ppi_state_e r_state, w_nxt;
  logic       r_ncs, r_nre, r_nwr, r_prst, r_doe, r_wr, r_rsp, r_srst_pend;
  logic [1:0] r_a;
  logic [7:0] r_wdata, r_rdata;
  logic       w_hs, w_done, w_load, w_srst, w_bus, w_wr, w_rsp;
  logic [W-1:0] w_val;

  ppi_cyc_timer #(.W(W), .RST_VAL(RESET_CYC)) u_timer (
    .clk    (clk),
    .nReset (nReset),
    .i_load (w_load),
    .i_val  (w_val),
    .o_done (w_done)
  );

  assign req_ready = (r_state == ST_IDLE) & ~soft_rst;
  assign w_hs      = req_ready & req_valid;
  assign w_srst    = r_srst_pend | soft_rst;
  assign w_wr      = w_hs ? req_write : r_wr;
  assign w_bus     = w_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD};
  // HOLD exit is both IDLE entry and RECOV entry, so one term covers either build.
  assign w_rsp     = (r_state == ST_HOLD) & w_done & ~r_wr;

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_val  = W'(RESET_CYC);
    case (r_state)
      ST_PRST: begin
        w_load = soft_rst;
        w_nxt  = (!soft_rst && w_done) ? ST_IDLE : ST_PRST;
      end
      ST_IDLE: begin
        w_load = soft_rst | w_hs;
        w_val  = soft_rst ? W'(RESET_CYC) : W'(SETUP_CYC);
        w_nxt  = soft_rst ? ST_PRST : (w_hs ? ST_SETUP : ST_IDLE);
      end
      ST_SETUP: begin
        w_load = w_done;
        w_val  = W'(STROBE_CYC);
        w_nxt  = w_done ? ST_STROBE : ST_SETUP;
      end
      ST_STROBE: begin
        w_load = w_done;
        w_val  = W'(HOLD_CYC);
        w_nxt  = w_done ? ST_HOLD : ST_STROBE;
      end
`ifdef PPI_BUS_RECOVERY_EN
      ST_HOLD: begin
        w_load = w_done;
        w_val  = W'(RECOV_CYC);
        w_nxt  = w_done ? ST_RECOV : ST_HOLD;
      end
      ST_RECOV: begin
        w_load = w_done & w_srst;
        w_nxt  = w_done ? (w_srst ? ST_PRST : ST_IDLE) : ST_RECOV;
      end
`else
      ST_HOLD: begin
        w_load = w_done & w_srst;
        w_nxt  = w_done ? (w_srst ? ST_PRST : ST_IDLE) : ST_HOLD;
      end
`endif
      default: w_nxt = ST_PRST;
    endcase
  end

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      r_state     <= ST_PRST;
      r_ncs       <= 1'b1;
      r_nre       <= 1'b1;
      r_nwr       <= 1'b1;
      r_prst      <= 1'b1;
      r_doe       <= 1'b0;
      r_wr        <= 1'b0;
      r_rsp       <= 1'b0;
      r_srst_pend <= 1'b0;
      r_a         <= 2'b00;
      r_wdata     <= 8'h00;
      r_rdata     <= 8'h00;
    end else begin
      r_state     <= w_nxt;
      r_ncs       <= ~w_bus;
      r_nre       <= ~((w_nxt == ST_STROBE) & ~w_wr);
      r_nwr       <= ~((w_nxt == ST_STROBE) & w_wr);
      r_prst      <= (w_nxt == ST_PRST);
      r_doe       <= w_bus & w_wr;
      r_rsp       <= w_rsp;
      // A soft reset seen mid-cycle is parked until the cycle finishes.
      r_srst_pend <= (w_nxt != ST_PRST) &
                     (r_srst_pend | (soft_rst & (r_state != ST_IDLE) & (r_state != ST_PRST)));
      if (w_hs) begin
        r_wr    <= req_write;
        r_a     <= req_addr;
        r_wdata <= req_wdata;
      end
      if ((r_state == ST_STROBE) && w_done && !r_wr) r_rdata <= D;
    end

  assign D         = r_doe ? r_wdata : 8'hzz;
  assign nCs       = r_ncs;
  assign nRe       = r_nre;
  assign nWr       = r_nwr;
  assign ppi_reset = r_prst;
  assign A         = r_a;
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: table-driven bus-cycle checks plus directed soft-reset,
// back-to-back and mid-cycle reset sequences. D is pulled up so an undriven bus reads FF.
module tb_ppi_bus_master;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [1:0] req_addr = 2'b00;
  logic [7:0] req_wdata = 8'h00;
  logic       soft_rst = 1'b0;
  wire        req_ready, rsp_valid, busy, nCs, nRe, nWr, ppi_reset;
  wire  [1:0] A;
  wire  [7:0] rsp_rdata;
  tri1  [7:0] d_bus;

  logic       tb_drv = 1'b0;
  logic [7:0] tb_val = 8'h00;
  int         tests = 0;
  int         fails = 0;
  int         both_low = 0;

  assign d_bus = (tb_drv && !nRe) ? tb_val : 8'hzz;

  ppi_bus_master dut (
    .clk       (clk),
    .nReset    (nReset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .soft_rst  (soft_rst),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .nCs       (nCs),
    .nRe       (nRe),
    .nWr       (nWr),
    .ppi_reset (ppi_reset),
    .A         (A),
    .D         (d_bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!nRe && !nWr) both_low++;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] bus;
    int         exp_rsp;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic count_prst(output int n);
    n = 0;
    while (ppi_reset && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int ncs = 0, str = 0, wrong = 0, first = 0, rsp = 0, rsp_k = 0, dbad = 0, abad = 0;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    tb_drv    = !v.wr;
    tb_val    = v.bus;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!nCs) begin
        ncs++;
        if (A != v.addr) abad++;
        if (v.wr && d_bus != v.wdata) dbad++;
      end
      if (v.wr ? !nWr : !nRe) begin
        str++;
        if (first == 0) first = k;
      end
      if (v.wr ? !nRe : !nWr) wrong++;
      if (!v.wr && nRe && d_bus != 8'hff) dbad++;
      if (nCs && d_bus != 8'hff) dbad++;
      if (rsp_valid) begin
        rsp++;
        if (rsp_k == 0) rsp_k = k;
      end
    end
    tb_drv = 1'b0;
    chk({tag, " ncs_low"}, ncs, 4);
    chk({tag, " strobe_low"}, str, 2);
    chk({tag, " strobe_start"}, first, 2);
    chk({tag, " other_strobe"}, wrong, 0);
    chk({tag, " addr"}, abad, 0);
    chk({tag, " dbus"}, dbad, 0);
    chk({tag, " rsp_cnt"}, rsp, v.exp_rsp);
    chk({tag, " rsp_cycle"}, rsp_k, v.exp_rsp ? 5 : 0);
    chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " idle_ready"}, {busy, req_ready}, 2'b01);
  endtask

  logic ncs_s[1:14];
  logic rdy_s[1:14];
  logic prst_s[1:14];

  initial begin
    int n, c0, c1, c2, c3, first;
    vec_t fin;
    vecs[0] = '{1'b1, 2'b11, 8'h80, 8'h00, 0, 8'h00};
    vecs[1] = '{1'b0, 2'b00, 8'h00, 8'h5A, 1, 8'h5A};
    vecs[2] = '{1'b1, 2'b01, 8'h3C, 8'h00, 0, 8'h5A};
    vecs[3] = '{1'b0, 2'b10, 8'h00, 8'hA5, 1, 8'hA5};
    vecs[4] = '{1'b0, 2'b01, 8'h00, 8'h00, 1, 8'h00};
    vecs[5] = '{1'b1, 2'b00, 8'h0F, 8'h00, 0, 8'h00};
    vecs[6] = '{1'b0, 2'b11, 8'h00, 8'hC3, 1, 8'hC3};

    // Reset state
    @(negedge clk);
    chk("rst ppi_reset", ppi_reset, 1);
    chk("rst strobes", {nCs, nRe, nWr}, 3'b111);
    chk("rst ready_busy", {req_ready, busy}, 2'b01);
    chk("rst rsp", {rsp_valid, rsp_rdata}, 9'h000);
    chk("rst addr", A, 0);
    chk("rst dbus", d_bus, 8'hff);
    @(negedge clk);
    nReset = 1'b1;
    count_prst(n);
    chk("prst length", n, 4);
    chk("post_prst ready", req_ready, 1);
    chk("post_prst strobes", {nCs, nRe, nWr}, 3'b111);
    chk("post_prst dbus", d_bus, 8'hff);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: valid held, write 11/90 then read 00
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b11; req_wdata = 8'h90;
    tb_drv = 1'b1; tb_val = 8'h77;
    @(posedge clk);
    #1 req_write = 1'b0; req_addr = 2'b00; req_wdata = 8'h00;
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      ncs_s[k] = nCs;
      rdy_s[k] = req_ready;
      if (!nWr) c0++;
      if (!nRe) c1++;
      if (rsp_valid) c2++;
      if (k <= 4 && d_bus != 8'h90) c3++;
      if (k == 6) req_valid = 1'b0;
    end
    tb_drv = 1'b0;
    chk("b2b first_hold_ncs", ncs_s[4], 0);
    chk("b2b gap_ncs", ncs_s[5], 1);
    chk("b2b gap_ready", rdy_s[5], 1);
    chk("b2b second_ncs", ncs_s[6], 0);
    chk("b2b nwr_low", c0, 2);
    chk("b2b nre_low", c1, 2);
    chk("b2b rsp_cnt", c2, 1);
    chk("b2b wdata", c3, 0);
    chk("b2b rdata", rsp_rdata, 8'h77);

    // soft_rst during the STROBE of a read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'b10;
    tb_drv = 1'b1; tb_val = 8'h3C;
    @(posedge clk);
    #1 req_valid = 1'b0;
    c0 = 0; c1 = 0; c2 = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) soft_rst = 1'b0;
      prst_s[k] = ppi_reset;
      rdy_s[k] = req_ready;
      if (ppi_reset) begin
        c0++;
        if (first == 0) first = k;
      end
      if (k <= 8 && req_ready) c1++;
      if (rsp_valid) c2 += k;
      if (k == 2) soft_rst = 1'b1;
    end
    tb_drv = 1'b0;
    chk("srst_rd prst_len", c0, 4);
    chk("srst_rd prst_start", first, 5);
    chk("srst_rd ready_low", c1, 0);
    chk("srst_rd ready_after", rdy_s[9], 1);
    chk("srst_rd rsp_cycle", c2, 5);
    chk("srst_rd rdata", rsp_rdata, 8'h3C);

    // soft_rst in IDLE beats a simultaneous request
    soft_rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b00; req_wdata = 8'h11;
    #1 chk("srst_idle ready", req_ready, 0);
    @(posedge clk);
    #1 soft_rst = 1'b0; req_valid = 1'b0;
    c0 = 0; c1 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ppi_reset) c0++;
      if (!nCs) c1++;
    end
    chk("srst_idle prst_len", c0, 4);
    chk("srst_idle no_cycle", c1, 0);
    chk("srst_idle ready_after", req_ready, 1);

    // nReset during a write STROBE
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b00; req_wdata = 8'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst pre nwr", nWr, 0);
    chk("arst pre dbus", d_bus, 8'hAA);
    nReset = 1'b0;
    #1;
    chk("arst strobes", {nCs, nRe, nWr}, 3'b111);
    chk("arst dbus", d_bus, 8'hff);
    chk("arst rsp_prst", {rsp_valid, ppi_reset}, 2'b01);
    @(negedge clk);
    nReset = 1'b1;
    c2 = 0;
    n = 0;
    while (ppi_reset && n < 50) begin
      n++;
      if (rsp_valid) c2++;
      @(negedge clk);
    end
    chk("arst prst_len", n, 4);
    chk("arst no_rsp", c2, 0);
    chk("arst rdata_cleared", rsp_rdata, 8'h00);
    fin = '{1'b0, 2'b11, 8'h00, 8'h42, 1, 8'h42};
    run_txn(fin, "post_arst");

    chk("no_dual_strobe", both_low, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
